// File: rtl/jtag_instruction_register_param_pkg.sv
// Shared constants for the FABulous JTAG TAP: TAP state codes and IR defaults.
package jtag_instruction_register_param_pkg;

    // TAP controller state encoding shared by every TAP block.
    typedef enum logic [3:0] {
        TAP_EXIT2_DR      = 4'h0,
        TAP_EXIT1_DR      = 4'h1,
        TAP_SHIFT_DR      = 4'h2,
        TAP_PAUSE_DR      = 4'h3,
        TAP_SELECT_IR     = 4'h4,
        TAP_UPDATE_DR     = 4'h5,
        TAP_CAPTURE_DR    = 4'h6,
        TAP_SELECT_DR     = 4'h7,
        TAP_EXIT2_IR      = 4'h8,
        TAP_EXIT1_IR      = 4'h9,
        TAP_SHIFT_IR      = 4'hA,
        TAP_PAUSE_IR      = 4'hB,
        TAP_RUN_TEST_IDLE = 4'hC,
        TAP_UPDATE_IR     = 4'hD,
        TAP_CAPTURE_IR    = 4'hE,
        TAP_TLR           = 4'hF
    } tap_state_e;

    // Default instruction set: 0 BYPASS, 1 IDCODE, 2 SAMPLE/PRELOAD, 3 EXTEST, 4 PROGRAM, 5 INTEST.
    localparam int unsigned DEF_IR_LEN      = 4;
    localparam int unsigned DEF_NUM_INSTR   = 6;
    localparam int unsigned DEF_RESET_INSTR = 1;
    localparam logic [DEF_NUM_INSTR*DEF_IR_LEN-1:0] DEF_OPCODES =
        {4'b0110, 4'b0101, 4'b0000, 4'b0010, 4'b0001, 4'b1111};

    // Fixed low bits loaded on Capture-IR (IEEE 1149.1 "01" pattern).
    localparam logic [1:0] CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/ir_opcode_decoder.sv
// Opcode-table decoder: one-hot instruction select with BYPASS (index 0) fallback.
module ir_opcode_decoder
    import jtag_instruction_register_param_pkg::*;
#(
    parameter int unsigned IR_LEN    = DEF_IR_LEN,
    parameter int unsigned NUM_INSTR = DEF_NUM_INSTR,
    parameter logic [NUM_INSTR*IR_LEN-1:0] OPCODES = DEF_OPCODES
) (
    input  logic [IR_LEN-1:0]    i_opcode,
    output logic [NUM_INSTR-1:0] o_onehot
);

    logic [NUM_INSTR-1:0] w_match;
    logic [NUM_INSTR-1:0] w_match_hi;

    // Compare the opcode against every table slice in parallel.
    for (genvar g = 0; g < NUM_INSTR; g++) begin : g_match
        assign w_match[g] = (i_opcode == OPCODES[g*IR_LEN +: IR_LEN]);
    end

    // Lowest matching non-BYPASS entry wins; BYPASS opcode or no match selects bit 0.
    always_comb begin
        w_match_hi = w_match & ~NUM_INSTR'(1);
        o_onehot   = NUM_INSTR'(1);
        if (!w_match[0] && (w_match_hi != '0)) begin
            o_onehot = w_match_hi & (~w_match_hi + NUM_INSTR'(1));
        end
    end

endmodule

// File: rtl/jtag_instruction_register_param.sv
// Parametrised JTAG instruction register: capture/shift/update with opcode decode,
// update strobe and shift-length checking.
module jtag_instruction_register_param
    import jtag_instruction_register_param_pkg::*;
#(
    parameter int unsigned IR_LEN      = DEF_IR_LEN,
    parameter int unsigned NUM_INSTR   = DEF_NUM_INSTR,
    parameter logic [NUM_INSTR*IR_LEN-1:0] OPCODES = DEF_OPCODES,
    parameter int unsigned RESET_INSTR = DEF_RESET_INSTR
) (
    input  logic                 clkIR,
    input  logic                 resetn,
    input  logic [3:0]           tap_state,
    input  logic                 tdi,
    input  logic [IR_LEN-3:0]    status,
    output logic                 tdo,
    output logic [IR_LEN-1:0]    instr_code,
    output logic [NUM_INSTR-1:0] instr_onehot,
    output logic                 instr_update,
    output logic                 len_error
);

    localparam int unsigned CNT_W = $clog2(IR_LEN + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(IR_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX      = CNT_W'(IR_LEN + 1);
    localparam logic [IR_LEN-1:0] SR_RESET     = IR_LEN'(CAPTURE_LSBS);
    localparam logic [IR_LEN-1:0] RESET_OPCODE = OPCODES[RESET_INSTR*IR_LEN +: IR_LEN];

    // Reject parameter sets that cannot form a legal register or table.
    if (IR_LEN < 2) begin : g_bad_ir_len
        $error("jtag_instruction_register_param: IR_LEN must be at least 2");
    end
    if (NUM_INSTR < 1) begin : g_bad_num_instr
        $error("jtag_instruction_register_param: NUM_INSTR must be at least 1");
    end
    if (RESET_INSTR >= NUM_INSTR) begin : g_bad_reset_instr
        $error("jtag_instruction_register_param: RESET_INSTR must be below NUM_INSTR");
    end

    logic [IR_LEN-1:0] r_sr;
    logic [IR_LEN-1:0] r_upd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_update;
    logic              r_len_error;
    logic [NUM_INSTR-1:0] w_onehot;

    // Capture the status pattern, shift LSB-first and count shifts (saturating).
    always_ff @(posedge clkIR or negedge resetn) begin
        if (!resetn) begin
            r_sr  <= SR_RESET;
            r_cnt <= '0;
        end else begin
            case (tap_state)
                TAP_CAPTURE_IR: begin
                    r_sr  <= {status, CAPTURE_LSBS};
                    r_cnt <= '0;
                end
                TAP_SHIFT_IR: begin
                    r_sr <= {tdi, r_sr[IR_LEN-1:1]};
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Latch the instruction on Update-IR, restore the default in Test-Logic-Reset.
    always_ff @(posedge clkIR or negedge resetn) begin
        if (!resetn) begin
            r_upd       <= RESET_OPCODE;
            r_update    <= 1'b0;
            r_len_error <= 1'b0;
        end else begin
            r_update <= (tap_state == TAP_UPDATE_IR);
            if (tap_state == TAP_UPDATE_IR) begin
                r_upd       <= r_sr;
                r_len_error <= (r_cnt != CNT_FULL);
            end else if (tap_state == TAP_TLR) begin
                r_upd       <= RESET_OPCODE;
                r_len_error <= 1'b0;
            end
        end
    end

    ir_opcode_decoder #(
        .IR_LEN   (IR_LEN),
        .NUM_INSTR(NUM_INSTR),
        .OPCODES  (OPCODES)
    ) u_decoder (
        .i_opcode(r_upd),
        .o_onehot(w_onehot)
    );

    assign tdo          = r_sr[0];
    assign instr_code   = r_upd;
    assign instr_onehot = w_onehot;
    assign instr_update = r_update;
    assign len_error    = r_len_error;

endmodule

// File: doc/jtag_instruction_register_param.md
# jtag_instruction_register_param

Parametrised JTAG instruction register for the FABulous JTAG TAP. It captures a status pattern, shifts an instruction of configurable length between TDI and TDO, and latches it on Update-IR. It decodes the latched opcode through a parameter-supplied opcode table into a one-hot instruction bus for the data-register muxes. It also adds a reset-default instruction, update strobe, and shift-length checking.

## Interface
- IR_LEN, 4: instruction register length in bits; ≥2.
- NUM_INSTR, 6: number of decoded instructions (one-hot width); index 0 is always BYPASS.
- OPCODES, {4'b0110,4'b0101,4'b0000,4'b0010,4'b0001,4'b1111}: flat NUM_INSTR*IR_LEN table; slice k = opcode of instruction k (k=0 is the LSB slice). Defaults: 0 BYPASS, 1 IDCODE, 2 SAMPLE/PRELOAD, 3 EXTEST, 4 PROGRAM, 5 INTEST.
- RESET_INSTR, 1: index loaded at reset and in Test-Logic-Reset.

- clkIR  in  1  TCK-derived IR clock; all flops rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- tap_state  in  4  current TAP state code (shared constants).
- tdi  in  1  serial data in.
- status  in  IR_LEN-2  captured into bits [IR_LEN-1:2] on Capture-IR.
- tdo  out  1  serial data out, = shift_reg[0].
- instr_code  out  IR_LEN  latched opcode.
- instr_onehot  out  NUM_INSTR  decoded instruction, exactly one bit set.
- instr_update  out  1  one-cycle pulse after every Update-IR load.
- len_error  out  1  sticky: last update followed a shift of wrong length.

## Operation
- Shift register sr[IR_LEN-1:0], update register upd[IR_LEN-1:0], shift counter cnt (width clog2(IR_LEN+2)), saturating at IR_LEN+1.
- Capture-IR: sr <= {status, 2'b01}; cnt <= 0.
- Shift-IR: sr <= {tdi, sr[IR_LEN-1:1]} (LSB out first); cnt <= sat(cnt+1).
- Update-IR: upd <= sr; instr_update <= 1 next cycle; len_error <= (cnt != IR_LEN).
- Test-Logic-Reset: upd <= OPCODES slice RESET_INSTR; len_error <= 0; sr unchanged.
- Any other state: sr, cnt, and upd hold.
- Decode is combinational on upd: instr_onehot[k] = 1 for the lowest k whose slice equals upd, searched over k≥1. No match gives bit 0 (BYPASS). An opcode equal to BYPASS gives bit 0.
- instr_code = upd.
- Reset values: sr = {0…,2'b01}, upd = RESET_INSTR opcode, instr_onehot = 1<<RESET_INSTR, instr_update = 0, len_error = 0, cnt = 0, tdo = 1.

## Timing
- Capture, shift, and update take effect on the clkIR rising edge that ends the corresponding state cycle.
- instr_onehot and instr_code change on the same edge as upd. instr_update is high for exactly the following cycle.
- Back-to-back Update-IRs give one pulse per update.
- tdo is combinational from sr[0]; the first bit valid in Shift-IR is the captured bit 0 (=1).
- Shift counts above IR_LEN saturate at IR_LEN+1, so len_error is still set. Update without any Shift-IR gives cnt=0 and sets len_error.
- resetn assertion mid-shift restores all reset values asynchronously. The first shift after release needs a fresh Capture-IR.

## Structure
- TAP state codes live in the shared constants header (TLR, CAPTURE_IR, SHIFT_IR, UPDATE_IR). No local redefinition.
- Sub-module ir_opcode_decoder: parameters IR_LEN, NUM_INSTR, OPCODES; input opcode; output one-hot with BYPASS fallback. It is reused by future TAP variants.
- Elaboration check: IR_LEN≥2, NUM_INSTR≥1, RESET_INSTR<NUM_INSTR.

## Test plan
- Reset release with defaults → instr_onehot=6'b000010, instr_code=4'b0001, tdo=1, len_error=0.
- Capture-IR with status=2'b10, then 4 Shift-IR cycles with tdi=0 → tdo sequence 1,0,0,1.
- Capture, shift in 4'b0101 (LSB first), Update-IR → instr_onehot=6'b010000, instr_code=4'b0101. instr_update is high one cycle; len_error=0.
- Shift in 4'b1010 (unmapped), update → instr_onehot=6'b000001. A 3-bit or 6-bit shift followed by update → len_error=1 until TLR.
- With 4'b0110 loaded, enter TLR → instr_onehot=6'b000010 on the next edge and len_error cleared.
- Assert resetn in the middle of Shift-IR → all outputs return to reset values immediately. Parameter sweep with IR_LEN=8 and NUM_INSTR=3 repeats the load/decode checks.
